// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the fetch-side PC sequencer.
package pc_sequencer_pkg;

  localparam int PC_W_DEF     = 48;
  localparam int MEM_SIZE_DEF = 32;

  typedef logic [PC_W_DEF-1:0] pc_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } pc_state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC helpers: wrapping increment and branch-target range check.
module pc_next_calc #(
  parameter int PC_W     = 48,
  parameter int MEM_SIZE = 32
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic [PC_W-1:0] target_i,
  output logic [PC_W-1:0] pc_inc_o,
  output logic            target_oor_o
);

  localparam logic [PC_W-1:0] MEM_SIZE_W = PC_W'(MEM_SIZE);
  localparam logic [PC_W-1:0] ONE_W      = PC_W'(1);

  logic [PC_W-1:0] pc_plus;

  assign pc_plus      = pc_i + ONE_W;
  assign pc_inc_o     = (pc_plus == MEM_SIZE_W) ? '0 : pc_plus;
  assign target_oor_o = (target_i >= MEM_SIZE_W);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter owner and instruction-fetch sequencer.
// Optional accepted-fetch counter built only when PC_FETCH_CNT_EN is defined.
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   ST_IDLE  | out of reset, waiting for start
//   ST_FETCH | issuing fetches, PC advancing/redirecting
//   ST_HALT  | halt decoded, waiting for start to restart at 0
//   ST_FAULT | branch target out of range, cleared only by reset
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W     = PC_W_DEF,
  parameter int MEM_SIZE = MEM_SIZE_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            halt_req,
  input  logic            imem_ready,
  output logic            imem_req,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            fault,
  output logic [31:0]     fetch_cnt
);

  pc_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc;
  logic            target_oor;

  pc_next_calc #(
    .PC_W     (PC_W),
    .MEM_SIZE (MEM_SIZE)
  ) u_next (
    .pc_i         (pc_q),
    .target_i     (branch_target),
    .pc_inc_o     (pc_inc),
    .target_oor_o (target_oor)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    imem_req = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
        end
      end
      ST_FETCH: begin
        imem_req = !stall;
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (branch_taken) begin
          // Redirect wins over stall and abandons any request in flight.
          if (target_oor) begin
            state_d = ST_FAULT;
            pc_d    = '0;
          end else begin
            pc_d = branch_target;
          end
        end else if (!stall && imem_ready) begin
          pc_d = pc_inc;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
      end
    endcase
  end

  assign pc     = pc_q;
  assign halted = (state_q == ST_HALT) || (state_q == ST_FAULT);
  assign fault  = (state_q == ST_FAULT);

`ifdef PC_FETCH_CNT_EN
  logic [31:0] cnt_q;
  logic        cnt_clr;
  logic        cnt_inc;

  // Counts only fetches that actually advance the PC.
  assign cnt_clr = ((state_q == ST_IDLE) || (state_q == ST_HALT)) && start;
  assign cnt_inc = (state_q == ST_FETCH) && !halt_req && !branch_taken
                   && !stall && imem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (cnt_inc && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = cnt_q;
`else
  assign fetch_cnt = 32'd0;
`endif

endmodule
